// File: rtl/ss_timer_pkg.sv
// ss_timer_pkg: register map, CTRL field positions and byte-enable merge helper for ss_timer
package ss_timer_pkg;
  localparam logic [4:0] OFF_MTIME_LO = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI = 5'h04;
  localparam logic [4:0] OFF_CMP_LO   = 5'h08;
  localparam logic [4:0] OFF_CMP_HI   = 5'h0C;
  localparam logic [4:0] OFF_CTRL     = 5'h10;
  localparam logic [4:0] OFF_STATUS   = 5'h14;
  localparam logic [4:0] OFF_RSVD0    = 5'h18;
  localparam logic [4:0] OFF_RSVD1    = 5'h1C;
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_IE_BIT  = 1;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_DIV_MSB = 15;
  localparam int STATUS_PEND_BIT = 0;
  typedef enum logic [2:0] {
    REG_MTIME_LO = OFF_MTIME_LO[4:2],
    REG_MTIME_HI = OFF_MTIME_HI[4:2],
    REG_CMP_LO   = OFF_CMP_LO[4:2],
    REG_CMP_HI   = OFF_CMP_HI[4:2],
    REG_CTRL     = OFF_CTRL[4:2],
    REG_STATUS   = OFF_STATUS[4:2],
    REG_RSVD0    = OFF_RSVD0[4:2],
    REG_RSVD1    = OFF_RSVD1[4:2]
  } ss_timer_reg_e;
  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    for (int i = 0; i < 4; i++) be_merge[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
  endfunction
endpackage

// File: rtl/ss_timer_prescaler.sv
// ss_timer_prescaler: one-cycle tick every div+1 enabled cycles (built only with SS_TIMER_PRESCALE_EN)
`ifdef SS_TIMER_PRESCALE_EN
module ss_timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tick
);
  logic [W-1:0] r_cnt;
  // >= rather than == so a DIV lowered mid-count ticks at once instead of wrapping
  assign tick = en && (r_cnt >= div);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_cnt <= '0;
    else         r_cnt <= (!en || tick) ? '0 : r_cnt + 1'b1;
endmodule
`endif

// File: rtl/ss_timer.sv
// ss_timer: 64-bit memory-mapped machine timer with compare interrupt; SS_TIMER_PRESCALE_EN adds the CTRL.DIV prescaler
module ss_timer
  import ss_timer_pkg::*;
#(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        gnt,
  output logic        rvalid,
  output logic        err,
  output logic        irq
);
  ss_timer_reg_e         w_reg;
  logic [63:0]           r_mtime, r_cmp, w_mtime_inc, w_mtime_nxt;
  logic [31:0]           r_shadow, r_rdata, w_rd, w_ctrl;
  logic                  r_en, r_ie, r_pend, r_irq, r_rvalid, r_err;
  logic                  w_tick, w_wr, w_rd_en, w_unmapped, w_set, w_clr, w_unused;
  logic [PRESCALE_W-1:0] w_div;

  assign w_reg      = ss_timer_reg_e'(addr[4:2]);
  assign w_wr       = req && we;
  assign w_rd_en    = req && !we;
  assign w_unmapped = (w_reg == REG_RSVD0) || (w_reg == REG_RSVD1);
  assign w_unused   = ^{addr[31:5], addr[1:0]};
  assign gnt        = req;
  assign rdata      = r_rdata;
  assign rvalid     = r_rvalid;
  assign err        = r_err;
  assign irq        = r_irq;

`ifdef SS_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_div;
  assign w_div = r_div;
  ss_timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .en     (r_en),
    .div    (r_div),
    .tick   (w_tick)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)                                 r_div <= '0;
    else if (w_wr && w_reg == REG_CTRL && be[1]) r_div <= wdata[CTRL_DIV_LSB +: PRESCALE_W];
`else
  assign w_div  = '0;
  assign w_tick = r_en;
`endif

  always_comb begin
    w_ctrl = '0;
    w_ctrl[CTRL_DIV_LSB +: PRESCALE_W] = w_div;
    w_ctrl[CTRL_EN_BIT] = r_en;
    w_ctrl[CTRL_IE_BIT] = r_ie;
  end

  // a bus write beats the tick only for the bytes it enables
  assign w_mtime_inc = r_mtime + 64'(w_tick);
  always_comb begin
    w_mtime_nxt = w_mtime_inc;
    if (w_wr && w_reg == REG_MTIME_LO) w_mtime_nxt[31:0]  = be_merge(w_mtime_inc[31:0], wdata, be);
    if (w_wr && w_reg == REG_MTIME_HI) w_mtime_nxt[63:32] = be_merge(w_mtime_inc[63:32], wdata, be);
  end

  always_comb begin
    w_rd = '0;
    case (w_reg)
      REG_MTIME_LO: w_rd = r_mtime[31:0];
      REG_MTIME_HI: w_rd = r_shadow;
      REG_CMP_LO:   w_rd = r_cmp[31:0];
      REG_CMP_HI:   w_rd = r_cmp[63:32];
      REG_CTRL:     w_rd = w_ctrl;
      REG_STATUS:   w_rd = {31'b0, r_pend};
      default:      w_rd = '0;
    endcase
  end

  assign w_set = r_en && (r_mtime >= r_cmp);
  assign w_clr = w_wr && w_reg == REG_STATUS && be[0] && wdata[STATUS_PEND_BIT];

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_mtime  <= '0;
      r_cmp    <= CMP_RESET;
      r_en     <= 1'b0;
      r_ie     <= 1'b0;
      r_pend   <= 1'b0;
      r_irq    <= 1'b0;
      r_shadow <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_mtime <= w_mtime_nxt;
      if (w_wr && w_reg == REG_CMP_LO) r_cmp[31:0]  <= be_merge(r_cmp[31:0], wdata, be);
      if (w_wr && w_reg == REG_CMP_HI) r_cmp[63:32] <= be_merge(r_cmp[63:32], wdata, be);
      if (w_wr && w_reg == REG_CTRL && be[0]) begin
        r_en <= wdata[CTRL_EN_BIT];
        r_ie <= wdata[CTRL_IE_BIT];
      end
      r_pend <= w_set || (r_pend && !w_clr);
      r_irq  <= r_pend && r_ie;
      // shadow keeps HI coherent with the LO value just returned
      if (w_rd_en && w_reg == REG_MTIME_LO)   r_shadow <= r_mtime[63:32];
      else if (w_wr && w_reg == REG_MTIME_HI) r_shadow <= w_mtime_nxt[63:32];
      r_rdata  <= w_rd_en ? w_rd : '0;
      r_rvalid <= req;
      r_err    <= req && w_unmapped;
    end
endmodule

// File: tb/tb_ss_timer.sv
// tb_ss_timer: randomized and directed self-checking bench for ss_timer against a behavioural register model
module tb_ss_timer;
  logic        clk = 1'b0, resetn = 1'b1, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        gnt, rvalid, err, irq;
  int          n_tests = 0, n_fail = 0;
  logic [2:0]  a3;
  logic [31:0] v, v2;

  ss_timer dut (
    .clk(clk), .resetn(resetn), .req(req), .addr(addr), .we(we), .be(be),
    .wdata(wdata), .rdata(rdata), .gnt(gnt), .rvalid(rvalid), .err(err), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  logic [63:0] m_mt, m_cmp;
  logic [31:0] m_shadow, e_rdata;
  logic [7:0]  m_div;
  logic        m_en, m_ie, m_pend, m_irq, e_rvalid, e_err;
  logic        m_live = 1'b0;
  int          m_phase;

  always @(posedge clk) begin : model
    logic [63:0] nmt;
    logic [31:0] rd, cv;
    logic        tick, set, clr;
    int          idx, period;
    if (!resetn) begin
      m_mt = '0; m_cmp = '1; m_en = 0; m_ie = 0; m_div = '0; m_pend = 0; m_irq = 0;
      m_shadow = '0; m_phase = 0; e_rvalid = 0; e_rdata = '0; e_err = 0; m_live = 1;
    end else begin
      idx    = int'(addr[4:2]);
      period = int'(m_div) + 1;
      tick   = m_en && (m_phase + 1 >= period);
      set    = m_en && (m_mt >= m_cmp);
      clr    = req && we && idx == 5 && be[0] && wdata[0];
      cv     = {16'b0, m_div, 6'b0, m_ie, m_en};
      case (idx)
        0: rd = m_mt[31:0];
        1: rd = m_shadow;
        2: rd = m_cmp[31:0];
        3: rd = m_cmp[63:32];
        4: rd = cv;
        5: rd = {31'b0, m_pend};
        default: rd = '0;
      endcase
      e_rvalid = req;
      e_rdata  = (req && !we) ? rd : '0;
      e_err    = req && idx >= 6;
      m_irq    = m_pend && m_ie;
      m_phase  = (!m_en || tick) ? 0 : m_phase + 1;
      nmt      = m_mt + 64'(tick);
      if (req && !we && idx == 0) m_shadow = m_mt[63:32];
      if (req && we)
        case (idx)
          0: nmt[31:0] = bmerge(nmt[31:0], wdata, be);
          1: begin nmt[63:32] = bmerge(nmt[63:32], wdata, be); m_shadow = nmt[63:32]; end
          2: m_cmp[31:0]  = bmerge(m_cmp[31:0], wdata, be);
          3: m_cmp[63:32] = bmerge(m_cmp[63:32], wdata, be);
          4: begin
            cv = bmerge(cv, wdata, be);
            m_en = cv[0];
            m_ie = cv[1];
`ifdef SS_TIMER_PRESCALE_EN
            m_div = cv[15:8];
`endif
          end
          default: ;
        endcase
      m_pend = set || (m_pend && !clr);
      m_mt   = nmt;
    end
  end

  always @(posedge clk) begin : compare
    #1;
    if (m_live) begin
      chk("rvalid", rvalid, e_rvalid);
      chk("rdata", rdata, e_rdata);
      chk("err", err, e_err);
      chk("irq", irq, m_irq);
      chk("gnt", gnt, req);
    end
  end

  task automatic bus(input logic w, input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; addr = 32'h9a10_0020 | {27'b0, a}; be = b; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus(1'b1, a, 4'hF, d);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus(1'b0, a, 4'hF, '0);
    d = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #3 resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      rd(5'(4 * i), v);
      chk($sformatf("reset_rd%0d", i), v, (i == 2 || i == 3) ? 32'hFFFF_FFFF : 32'h0);
      chk("reset_rvalid", rvalid, 1'b1);
      chk("reset_err", err, 1'b0);
    end
    idle(1);

    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h04, 32'h0);
    wr(5'h10, 32'h1);
    idle(3);
    rd(5'h00, v);
    rd(5'h04, v2);
    chk("carry_lo", v, 32'h1);
    chk("carry_hi", v2, 32'h1);
    wr(5'h10, 32'h0);

    wr(5'h00, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h08, 32'h20);
    wr(5'h0C, 32'h0);
    wr(5'h10, 32'h3);
    idle(33);
    chk("irq_before", irq, 1'b0);
    idle(1);
    chk("irq_rise", irq, 1'b1);
    rd(5'h14, v);
    chk("pend_set", v, 32'h1);
    wr(5'h08, 32'h100);
    wr(5'h14, 32'h1);
    idle(1);
    chk("irq_cleared", irq, 1'b0);
    wr(5'h08, 32'h0);
    wr(5'h14, 32'h1);
    rd(5'h14, v);
    chk("w1c_vs_set", v, 32'h1);
    wr(5'h10, 32'h0);
    wr(5'h14, 32'h1);
    rd(5'h14, v);
    chk("w1c_clear", v, 32'h0);

    wr(5'h00, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h10, 32'h301);
    idle(40);
    wr(5'h10, 32'h300);
    rd(5'h00, v);
`ifdef SS_TIMER_PRESCALE_EN
    chk("presc_count_in_range", (v >= 9 && v <= 11), 1'b1);
`else
    chk("presc_count_in_range", (v >= 39 && v <= 41), 1'b1);
`endif
    rd(5'h10, v);
`ifdef SS_TIMER_PRESCALE_EN
    chk("ctrl_div", v[15:8], 8'h03);
`else
    chk("ctrl_div", v[15:8], 8'h00);
`endif

    wr(5'h08, 32'hFFFF_FFFF);
    bus(1'b1, 5'h08, 4'b0010, 32'hAABB_CCDD);
    rd(5'h08, v);
    chk("be_merge", v, 32'hFFFF_CCFF);

    bus(1'b0, 5'h18, 4'hF, '0);
    chk("unmapped_rvalid", rvalid, 1'b1);
    chk("unmapped_err", err, 1'b1);
    chk("unmapped_rdata", rdata, 32'h0);
    bus(1'b0, 5'h10, 4'hF, '0);
    chk("b2b_rvalid", rvalid, 1'b1);
    chk("b2b_err", err, 1'b0);
    idle(1);

    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h9a10_0028; be = 4'hF; resetn = 1'b0;
    @(posedge clk);
    #1 chk("rst_no_rvalid", rvalid, 1'b0);
    @(negedge clk);
    resetn = 1'b1; req = 1'b0;
    @(posedge clk);
    #1 chk("rst_release_rvalid", rvalid, 1'b0);
    rd(5'h08, v);
    chk("rst_cmp", v, 32'hFFFF_FFFF);

    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      a3    = 3'($urandom_range(0, 7));
      req   = ($urandom_range(0, 9) < 7);
      we    = 1'($urandom_range(0, 1));
      addr  = 32'h9a10_0020 | {27'b0, a3, 2'b00};
      be    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      wdata = $urandom;
      if (a3 == 3'd4) wdata = wdata & 32'h0000_0303;
      else if (a3 < 3'd4 && $urandom_range(0, 1) == 1) wdata = $urandom_range(0, 80);
      @(posedge clk);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ss_timer.md
# ss_timer

Memory-mapped 64-bit machine timer on the core's slave-side (`ss_`) data bus, alongside the UART. It consumes the same request stream the core drives onto the UART and returns read data on the shared `rdata` path. It provides a free-running `mtime`, a `mtimecmp` compare, a CTRL/STATUS pair and a level interrupt output. Base address is 0x9a10_0020, 32-byte window. The top level gates `req` with `ss_addr[31:5]==27'h4D08_001`.

## Interface
Parameters:
- `PRESCALE_W`, 8: prescaler divide field width (CTRL[15:8]).
- `CMP_RESET`, 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request, pre-decoded to this window.
- `addr`  in  32  byte address; only `addr[4:2]` used.
- `we`  in  1  1 = write, 0 = read.
- `be`  in  4  byte enables for writes.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, valid with `rvalid`, else 0.
- `gnt`  out  1  grant, combinational `= req`.
- `rvalid`  out  1  response strobe, one cycle after an accepted `req`.
- `err`  out  1  error flag, qualified by `rvalid`.
- `irq`  out  1  timer interrupt, level.

## Operation
Register map, by offset:
- 0x00 MTIME_LO (RW).
- 0x04 MTIME_HI (RW).
- 0x08 CMP_LO (RW).
- 0x0C CMP_HI (RW).
- 0x10 CTRL (RW): bit0 EN, bit1 IE, bits[15:8] DIV, others read 0.
- 0x14 STATUS: bit0 PEND, write-1-to-clear.
- 0x18 and 0x1C are unmapped. Read returns 0; write is dropped; `err`=1 with `rvalid`.

Counting:
- When EN=1, a tick occurs every DIV+1 cycles; `mtime` increments by 1 per tick.
- `mtime` is a 64-bit unsigned counter; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- When EN=0, the prescaler count resets to 0 and `mtime` holds.

Register writes:
- Writes honour `be` per byte.
- A write to MTIME_LO/HI in the same cycle as a tick wins; the written half takes wdata, and the other half takes the incremented value.

Compare and interrupt:
- PEND sets in any cycle where EN=1 and `mtime >= mtimecmp` (64-bit unsigned compare, registered values).
- A W1C clear in the same cycle as a set condition leaves PEND=1.
- `irq = PEND & IE`, registered.

Atomic 64-bit read:
- Reading MTIME_LO captures MTIME_HI into a shadow register.
- Reading MTIME_HI returns the shadow.
- Writing MTIME_HI also updates the shadow.

Reset values: `mtime`=0, `mtimecmp`=CMP_RESET, CTRL=0, PEND=0, shadow=0, `rdata`=0, `rvalid`=0, `err`=0, `irq`=0.

## Timing
- `gnt` is asserted in the same cycle as `req`; no wait states; one request per cycle.
- Read data is sampled at the `req` edge and presented with `rvalid` in cycle N+1.
- A write takes effect at the `req` edge; `rvalid` pulses in N+1 with `rdata`=0.
- Back-to-back requests produce back-to-back `rvalid` pulses.
- PEND rises one cycle after `mtime` reaches `mtimecmp`; `irq` follows one cycle later.
- `resetn` deassertion mid-transaction: no `rvalid` is issued for a request accepted while in reset.

## Configuration
`SS_TIMER_PRESCALE_EN`:
- Defined: prescaler instantiated; CTRL[15:8] is RW and the tick period is DIV+1.
- Undefined: no prescaler logic; CTRL[15:8] reads 0 and ignores writes; a tick occurs every cycle while EN=1.

## Structure
- `ss_timer_pkg`:
  - register offset constants;
  - CTRL bit positions;
  - `CTRL_DIV_LSB` and `CTRL_DIV_MSB`;
  - a `ss_timer_reg_e` enum decoded from `addr[4:2]`.
- Sub-module `ss_timer_prescaler`:
  - inputs: `clk`, `resetn`, `en`, `div`;
  - output: single-cycle `tick`;
  - compiled only under `SS_TIMER_PRESCALE_EN`.

## Test plan
- Reset, then read all six registers:
  - expect 0 for every register except CMP_LO/HI = 0xFFFF_FFFF;
  - `rvalid` in N+1 for each read;
  - `err`=0.
- EN=1, DIV=0:
  - write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0;
  - after 3 cycles, LO then HI reads give 0x0000_0001 / 0x0000_0001.
- CMP=0x20, EN=1, IE=1 from `mtime`=0:
  - PEND=1 one cycle after `mtime`==0x20, `irq`=1 the cycle after;
  - W1C STATUS with CMP raised to 0x100 → `irq`=0.
- With `SS_TIMER_PRESCALE_EN`, DIV=3: 40 cycles after EN produce `mtime`=10 ±1.
  - Without the macro: the same stimulus gives 40 ±1, and a CTRL readback shows bits[15:8]=0.
- Byte-enable write `be`=4'b0010, wdata=0xAABB_CCDD to CMP_LO → CMP_LO reads 0xFFFF_CCFF.
- Read 0x18 → `rvalid`=1, `err`=1, `rdata`=0; back-to-back read of 0x10 → `err`=0.
